// File: rtl/bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bist_pkg
//  Description : Shared types and helpers for the BIST session controller:
//                FSM state encoding, default CUT widths, shift-register tap
//                table and a single-step shift/feedback helper.
//  Revision    : 1.0  initial release
// ============================================================================
package bist_pkg;

    localparam int c_DEF_N_IN  = 35;
    localparam int c_DEF_N_OUT = 23;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SEED  = 3'd1,
        S_FLUSH = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } bist_state_e;

    // Feedback tap mask (bit i set => q[i] feeds the XOR) for a given width.
    // Widths outside the table fall back to the two top bits.
    function automatic logic [63:0] tap_mask(input int unsigned width);
        logic [63:0] m;
        case (width)
            4:       m = 64'h0000_0000_0000_000C;   // x^4+x^3+1
            8:       m = 64'h0000_0000_0000_00B8;   // x^8+x^6+x^5+x^4+1
            16:      m = 64'h0000_0000_0000_B400;   // x^16+x^14+x^13+x^11+1
            23:      m = 64'h0000_0000_0042_0000;   // x^23+x^18+1
            32:      m = 64'h0000_0000_8020_0003;   // x^32+x^22+x^2+x+1
            35:      m = 64'h0000_0005_0000_0000;   // x^35+x^33+1
            default: m = (64'd1 << (width - 1)) | (64'd1 << (width - 2));
        endcase
        return m;
    endfunction

    // One Fibonacci shift: new LSB is the XOR of the tapped bits. Bits at and
    // above 'width' are don't-care; callers truncate to their own width.
    function automatic logic [63:0] shift_step(input logic [63:0] q,
                                               input int unsigned width);
        logic fb;
        fb = ^(q & tap_mask(width));
        return {q[62:0], fb};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bist_lfsr_misr.sv
`default_nettype none
// ============================================================================
//  Module      : bist_lfsr_misr
//  Description : Width-parameterised Fibonacci shift register used both as
//                the pattern LFSR (compact off) and as the response MISR
//                (compact on, parallel data XORed in on every advance).
//  Revision    : 1.0  initial release
// ============================================================================
module bist_lfsr_misr
    import bist_pkg::*;
#(
    parameter int               WIDTH   = c_DEF_N_IN,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_clear,
    input  logic             i_advance,
    input  logic             i_compact,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_shift;
    logic [WIDTH-1:0] w_next;

    assign w_shift = WIDTH'(shift_step(64'(r_q), WIDTH));
    assign w_next  = i_compact ? (w_shift ^ i_data) : w_shift;
    assign o_q     = r_q;

    // Register update: load beats clear beats advance; otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= RST_VAL;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_clear) begin
            r_q <= '0;
        end else if (i_advance) begin
            r_q <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bist_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bist_session_ctrl
//  Description : BIST session sequencer. SEED reloads the LFSR and clears the
//                MISR, FLUSH clocks the core until its unreset flops are
//                determined by the pattern stream, RUN compacts N_PAT
//                responses, DONE presents the signature and pass/fail.
//  Revision    : 1.0  initial release
// ============================================================================
module bist_session_ctrl
    import bist_pkg::*;
#(
    parameter int                N_IN      = c_DEF_N_IN,
    parameter int                N_OUT     = c_DEF_N_OUT,
    parameter int                N_PAT     = 1024,
    parameter int                FLUSH_CYC = 19,
    parameter logic [N_IN-1:0]   SEED      = {{(N_IN-1){1'b0}}, 1'b1},
    parameter logic [N_OUT-1:0]  GOLDEN    = '0
) (
    input  logic              CK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic [N_OUT-1:0]  CUT_OUT,
    output logic [N_IN-1:0]   CUT_IN,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [N_OUT-1:0]  SIGNATURE
);

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [N_IN-1:0] c_SEED_EFF =
        (SEED == '0) ? {{(N_IN-1){1'b0}}, 1'b1} : SEED;
    localparam int c_MAXC = (N_PAT > FLUSH_CYC) ? N_PAT : FLUSH_CYC;
    localparam int c_CW   = $clog2(c_MAXC + 1);
    localparam logic [c_CW-1:0] c_FLUSH_LAST = c_CW'(FLUSH_CYC - 1);
    localparam logic [c_CW-1:0] c_RUN_LAST   = c_CW'(N_PAT - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE    = c_CW'(1);

    bist_state_e      r_state;
    bist_state_e      w_state_nxt;
    logic [c_CW-1:0]  r_cnt;
    logic             r_pass;

    logic             w_lfsr_load;
    logic             w_lfsr_adv;
    logic             w_misr_clr;
    logic             w_misr_adv;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_pass_set;
    logic             w_pass_clr;
    logic [N_OUT-1:0] w_misr_nxt;

    bist_lfsr_misr #(
        .WIDTH   (N_IN),
        .RST_VAL (c_SEED_EFF)
    ) u_lfsr (
        .clk        (CK),
        .rst        (RST),
        .i_load     (w_lfsr_load),
        .i_load_val (c_SEED_EFF),
        .i_clear    (1'b0),
        .i_advance  (w_lfsr_adv),
        .i_compact  (1'b0),
        .i_data     ({N_IN{1'b0}}),
        .o_q        (CUT_IN)
    );

    bist_lfsr_misr #(
        .WIDTH   (N_OUT),
        .RST_VAL ({N_OUT{1'b0}})
    ) u_misr (
        .clk        (CK),
        .rst        (RST),
        .i_load     (1'b0),
        .i_load_val ({N_OUT{1'b0}}),
        .i_clear    (w_misr_clr),
        .i_advance  (w_misr_adv),
        .i_compact  (1'b1),
        .i_data     (CUT_OUT),
        .o_q        (SIGNATURE)
    );

    // Value the MISR takes on the final RUN edge, for the registered verdict.
    assign w_misr_nxt = N_OUT'(shift_step(64'(SIGNATURE), N_OUT)) ^ CUT_OUT;

    // State register.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath controls; ABORT overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        w_lfsr_load = 1'b0;
        w_lfsr_adv  = 1'b0;
        w_misr_clr  = 1'b0;
        w_misr_adv  = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_pass_set  = 1'b0;
        w_pass_clr  = 1'b0;
        if (ABORT) begin
            w_state_nxt = S_IDLE;
            w_pass_clr  = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        w_state_nxt = S_SEED;
                    end
                end
                S_SEED: begin
                    w_lfsr_load = 1'b1;
                    w_misr_clr  = 1'b1;
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = (FLUSH_CYC == 0) ? S_RUN : S_FLUSH;
                end
                S_FLUSH: begin
                    w_lfsr_adv = 1'b1;
                    if (r_cnt == c_FLUSH_LAST) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = S_RUN;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                S_RUN: begin
                    w_lfsr_adv = 1'b1;
                    w_misr_adv = 1'b1;
                    if (r_cnt == c_RUN_LAST) begin
                        w_cnt_clr   = 1'b1;
                        w_pass_set  = 1'b1;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
                S_DONE: begin
                    if (START) begin
                        w_pass_clr  = 1'b1;
                        w_state_nxt = S_SEED;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Phase cycle counter, cleared at every phase boundary.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + c_CNT_ONE;
        end
    end

    // Pass verdict, captured on the last RUN edge and dropped on leaving DONE.
    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_pass <= 1'b0;
        end else if (w_pass_clr) begin
            r_pass <= 1'b0;
        end else if (w_pass_set) begin
            r_pass <= (w_misr_nxt == GOLDEN);
        end
    end

    assign BUSY = (r_state == S_SEED) || (r_state == S_FLUSH) || (r_state == S_RUN);
    assign DONE = (r_state == S_DONE);
    assign PASS = r_pass && (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_bist_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bist_session_ctrl
//  Description : Scoreboard bench for bist_session_ctrl. Four instances:
//                u_a (N_PAT=4, FLUSH_CYC=2), u_b/u_c (N_PAT=2, no flush,
//                GOLDEN 3/4, CUT_OUT=1), u_d (defaults, closed loop with a
//                small unreset stand-in core).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bist_session_ctrl;

    localparam logic [34:0] c_CORE_MASK = 35'h5_A5A5_A5A5;

    typedef struct {
        int          id;
        logic [22:0] sig;
        logic        pass;
    } exp_t;

    logic        CK = 1'b0;
    logic        RST;
    logic        start_a, abort_a, start_bc, start_d, abort_d;
    logic [22:0] cut_out_a;
    logic [22:0] core_out;
    logic [18:0] r_core;
    logic        scramble_req;
    logic [18:0] scramble_val;

    logic [34:0] cut_in_w [4];
    logic        busy_w   [4];
    logic        done_w   [4];
    logic        pass_w   [4];
    logic [22:0] sig_w    [4];
    logic        prev_done [4];

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 CK = ~CK;

    bist_session_ctrl #(.N_PAT(4), .FLUSH_CYC(2), .GOLDEN(23'h0)) u_a (
        .CK(CK), .RST(RST), .START(start_a), .ABORT(abort_a), .CUT_OUT(cut_out_a),
        .CUT_IN(cut_in_w[0]), .BUSY(busy_w[0]), .DONE(done_w[0]), .PASS(pass_w[0]),
        .SIGNATURE(sig_w[0]));

    bist_session_ctrl #(.N_PAT(2), .FLUSH_CYC(0), .GOLDEN(23'h3)) u_b (
        .CK(CK), .RST(RST), .START(start_bc), .ABORT(1'b0), .CUT_OUT(23'h1),
        .CUT_IN(cut_in_w[1]), .BUSY(busy_w[1]), .DONE(done_w[1]), .PASS(pass_w[1]),
        .SIGNATURE(sig_w[1]));

    bist_session_ctrl #(.N_PAT(2), .FLUSH_CYC(0), .GOLDEN(23'h4)) u_c (
        .CK(CK), .RST(RST), .START(start_bc), .ABORT(1'b0), .CUT_OUT(23'h1),
        .CUT_IN(cut_in_w[2]), .BUSY(busy_w[2]), .DONE(done_w[2]), .PASS(pass_w[2]),
        .SIGNATURE(sig_w[2]));

    bist_session_ctrl u_d (
        .CK(CK), .RST(RST), .START(start_d), .ABORT(abort_d), .CUT_OUT(core_out),
        .CUT_IN(cut_in_w[3]), .BUSY(busy_w[3]), .DONE(done_w[3]), .PASS(pass_w[3]),
        .SIGNATURE(sig_w[3]));

    // Stand-in core: 19 unreset flops, a shift register fed from the inputs.
    assign core_out = {r_core, 4'b0000} ^ cut_in_w[3][22:0];
    always @(posedge CK) begin
        if (scramble_req) r_core <= scramble_val;
        else              r_core <= {r_core[17:0], ^(cut_in_w[3] & c_CORE_MASK)};
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic push(input int id, input logic [22:0] sig, input logic pass);
        exp_t e;
        e.id = id; e.sig = sig; e.pass = pass;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input int idx, input int limit);
        int n;
        n = 0;
        while (!done_w[idx] && n < limit) begin
            tick();
            n++;
        end
        if (!done_w[idx]) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout_done inst=%0d waited=%0d", idx, n);
        end
        #2;
    endtask

    // Expected closed-loop signature from the LFSR/MISR polynomials and the core.
    function automatic logic [22:0] model_sig();
        logic [34:0] l;
        logic [18:0] s;
        logic [22:0] m;
        logic [22:0] o;
        l = 35'h1; s = '0; m = '0;
        for (int i = 0; i < 19; i++) begin
            s = {s[17:0], ^(l & c_CORE_MASK)};
            l = {l[33:0], l[34] ^ l[32]};
        end
        for (int i = 0; i < 1024; i++) begin
            o = {s, 4'b0000} ^ l[22:0];
            m = {m[21:0], m[22] ^ m[17]} ^ o;
            s = {s[17:0], ^(l & c_CORE_MASK)};
            l = {l[33:0], l[34] ^ l[32]};
        end
        return m;
    endfunction

    // Monitor: every DONE rising edge pops one expected result.
    initial for (int i = 0; i < 4; i++) prev_done[i] = 1'b0;
    always @(posedge CK) begin
        exp_t e;
        #2;
        for (int i = 0; i < 4; i++) begin
            if (done_w[i] && !prev_done[i]) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done inst=%0d sig=%0h", i, sig_w[i]);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("sb_inst%0d_id", i), 64'(i), 64'(e.id));
                    check($sformatf("sb_inst%0d_sig", i), 64'(sig_w[i]), 64'(e.sig));
                    check($sformatf("sb_inst%0d_pass", i), 64'(pass_w[i]), 64'(e.pass));
                end
            end
            prev_done[i] = done_w[i];
        end
    end

    initial begin
        logic [22:0] gold_d;
        int          busy_cnt;
        RST = 1'b1; start_a = 0; abort_a = 0; start_bc = 0; start_d = 0; abort_d = 0;
        cut_out_a = '0; scramble_req = 1'b1; scramble_val = 19'h2C3A1 ^ 19'($urandom);
        gold_d = model_sig();
        repeat (3) tick();
        scramble_req = 1'b0;
        RST = 1'b0;
        tick();

        // Reset state
        check("rst_busy", 64'(busy_w[0]), 64'd0);
        check("rst_done", 64'(done_w[0]), 64'd0);
        check("rst_pass", 64'(pass_w[0]), 64'd0);
        check("rst_sig", 64'(sig_w[0]), 64'd0);
        check("rst_cut_in", 64'(cut_in_w[0]), 64'h1);

        // u_a: N_PAT=4, FLUSH_CYC=2, CUT_OUT=0
        push(0, 23'h0, 1'b1);
        start_a = 1'b1;
        busy_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) start_a = 1'b0;
            if (busy_w[0]) busy_cnt++;
            if (k >= 2) check($sformatf("a_cut_in_e%0d", k), 64'(cut_in_w[0]), 64'd1 << (k - 2));
            if (k == 7) check("a_done_e7", 64'(done_w[0]), 64'd0);
            if (k == 8) check("a_done_e8", 64'(done_w[0]), 64'd1);
        end
        check("a_busy_cycles", 64'(busy_cnt), 64'd7);
        tick();

        // u_b / u_c: CUT_OUT=1, two patterns -> signature 3
        push(1, 23'h3, 1'b1);
        push(2, 23'h3, 1'b0);
        start_bc = 1'b1;
        tick();
        start_bc = 1'b0;
        wait_done(2, 20);

        // u_a: START held high; ignored while busy, restarts from DONE
        push(0, 23'h0, 1'b1);
        start_a = 1'b1;
        tick();
        check("held_done_e1", 64'(done_w[0]), 64'd0);
        check("held_pass_e1", 64'(pass_w[0]), 64'd0);
        busy_cnt = 1;
        for (int k = 2; k <= 8; k++) begin
            tick();
            if (busy_w[0]) busy_cnt++;
        end
        check("held_busy_cycles", 64'(busy_cnt), 64'd7);
        check("held_done_e8", 64'(done_w[0]), 64'd1);
        push(0, 23'h0, 1'b1);
        tick();
        check("held_restart_done", 64'(done_w[0]), 64'd0);
        check("held_restart_pass", 64'(pass_w[0]), 64'd0);
        check("held_restart_busy", 64'(busy_w[0]), 64'd1);
        start_a = 1'b0;
        wait_done(0, 20);

        // u_d: closed loop, first session
        push(3, gold_d, gold_d == 23'h0);
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        wait_done(3, 1200);

        // u_d: ABORT in the 3rd FLUSH cycle with START also high
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        tick();
        check("abort_lfsr_seeded", 64'(cut_in_w[3]), 64'h1);
        tick();
        tick();
        abort_d = 1'b1;
        start_d = 1'b1;
        tick();
        abort_d = 1'b0;
        start_d = 1'b0;
        check("abort_busy", 64'(busy_w[3]), 64'd0);
        check("abort_done", 64'(done_w[3]), 64'd0);
        check("abort_lfsr_hold", 64'(cut_in_w[3]), 64'h4);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("abort_idle_done", 64'(done_w[3]), 64'd0);
            check("abort_idle_lfsr", 64'(cut_in_w[3]), 64'h4);
        end

        // u_d: scramble core flops, second session must reproduce the signature
        scramble_val = 19'($urandom) ^ 19'h5A5A5;
        scramble_req = 1'b1;
        tick();
        scramble_req = 1'b0;
        push(3, gold_d, gold_d == 23'h0);
        start_d = 1'b1;
        tick();
        start_d = 1'b0;
        wait_done(3, 1200);

        // u_a: asynchronous reset in the middle of RUN
        cut_out_a = 23'h5;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (5) tick();
        check("mid_run_sig", 64'(sig_w[0]), 64'hF);
        check("mid_run_busy", 64'(busy_w[0]), 64'd1);
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_busy", 64'(busy_w[0]), 64'd0);
        check("async_rst_done", 64'(done_w[0]), 64'd0);
        check("async_rst_pass", 64'(pass_w[0]), 64'd0);
        check("async_rst_sig", 64'(sig_w[0]), 64'd0);
        check("async_rst_cut_in", 64'(cut_in_w[0]), 64'h1);
        tick();
        RST = 1'b0;
        repeat (2) tick();

        check("sb_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bist_session_ctrl.md
Name: bist_session_ctrl

Overview:
- Built-in self-test session controller for an ISCAS-class sequential benchmark core (s713-sized: 35 primary inputs, 23 primary outputs, 19 unreset flops).
- An LFSR drives the core's primary inputs; a MISR compacts the core's primary outputs.
- An FSM sequences seed, flush, run and done phases, then compares the final signature against a golden value.
- Sits beside the core under test, on the same CK; the core itself has no reset.

Parameters:
- N_IN, 35, LFSR width and CUT_IN width.
- N_OUT, 23, MISR width and CUT_OUT width.
- N_PAT, 1024, number of compacted patterns; must be >=1.
- FLUSH_CYC, 19, patterns applied before compaction so the core's unreset flops reach known state; 0 skips the flush phase.
- SEED, 35'h1, LFSR load value; an all-zero SEED is replaced by 1.
- GOLDEN, 23'h0, expected final signature.

Ports:
- CK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- START  in  1  level; sampled only in IDLE and DONE.
- ABORT  in  1  returns to IDLE from any state; no DONE is produced.
- CUT_OUT  in  N_OUT  core primary outputs.
- CUT_IN  out  N_IN  core primary inputs; always equal to the LFSR register.
- BUSY  out  1  high in SEED, FLUSH and RUN.
- DONE  out  1  high while in the DONE state.
- PASS  out  1  valid while DONE=1; otherwise 0.
- SIGNATURE  out  N_OUT  MISR register contents.

Behaviour:
- Reset is asynchronous and active-high on RST. Reset values:
  - state=IDLE, LFSR=SEED (so CUT_IN=SEED), MISR=0, count=0.
  - BUSY=0, DONE=0, PASS=0.
- FSM states: IDLE, SEED, FLUSH, RUN, DONE.
- IDLE:
  - START=1 at an edge -> SEED.
- SEED (exactly 1 cycle):
  - At its closing edge: LFSR<=SEED, MISR<=0, count<=0.
  - Next state is FLUSH, or RUN if FLUSH_CYC=0.
- FLUSH (FLUSH_CYC cycles):
  - Each edge advances the LFSR; MISR holds.
  - After FLUSH_CYC edges: count<=0, next state RUN.
- RUN (N_PAT cycles):
  - Each edge advances the LFSR and compacts the CUT_OUT value present before that edge. That value is the core's response to the current CUT_IN.
  - After N_PAT edges -> DONE.
  - PASS<=(MISR_next==GOLDEN) is registered on the same edge.
- DONE:
  - DONE=1 and PASS are held, and SIGNATURE is frozen, until START or ABORT.
  - START=1 -> SEED, which clears PASS.
- ABORT:
  - Has priority over START and all phase transitions.
  - Next state IDLE; PASS<=0; LFSR and MISR hold their values.
- START in SEED, FLUSH or RUN is ignored.
- LFSR (Fibonacci, x^35+x^33+1): lfsr_next = {lfsr[33:0], lfsr[34]^lfsr[32]}.
- MISR (x^23+x^18+1): misr_next = {misr[21:0], misr[22]^misr[17]} ^ CUT_OUT.
- Latency: START edge to DONE=1 is exactly 1+FLUSH_CYC+N_PAT+1 edges; BUSY is high for 1+FLUSH_CYC+N_PAT cycles.
- Counter width: $clog2(max(N_PAT,FLUSH_CYC)+1). No wrap occurs within a phase.
- Tap positions for the default widths are fixed as above. Other widths take their taps from the package table.

Decomposition:
- Shared package bist_pkg holds:
  - the state enum typedef;
  - the tap-table function returning the tap mask for a given width;
  - default N_IN and N_OUT constants.
- One natural sub-module, bist_lfsr_misr: a width-parameterised shift register with load, clear, advance and compact-enable controls. Instantiate it twice, once as the LFSR (CUT_OUT input tied to 0) and once as the MISR.
- The FSM and counter stay in the top module.

Test Plan:
- Reset: assert RST mid-RUN -> BUSY=0, DONE=0, PASS=0, SIGNATURE=0, CUT_IN=35'h1 immediately (asynchronous), without waiting for a CK edge.
- N_PAT=4, FLUSH_CYC=2, CUT_OUT tied 0, GOLDEN=0, START pulse:
  - BUSY high for 7 cycles; DONE=1 on edge 8.
  - SIGNATURE=0, PASS=1.
  - CUT_IN sequence 1, 2, 4, 8, 16, 32, 64.
- N_PAT=2, FLUSH_CYC=0, CUT_OUT=23'h1 constant, GOLDEN=23'h3:
  - SIGNATURE=23'h3, PASS=1.
  - Rerun with GOLDEN=23'h4 -> PASS=0.
- ABORT asserted in 3rd FLUSH cycle while START is also high -> IDLE next edge, DONE never set, LFSR holds.
- START held high through a session -> ignored while BUSY; in DONE, a new session starts on the next edge and PASS clears.
- Closed-loop with s713 instance on CUT_IN/CUT_OUT, defaults:
  - Two consecutive sessions yield identical SIGNATURE, proving the flush phase makes the core state deterministic.
  - Record that signature as GOLDEN.
